// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// byte-strobe patterns, FSM states and the access-fault rule.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RESP,
        LSU_DONE
    } lsu_state_e;

    // Unsigned variants only exist for loads; anything else is illegal.
    function automatic logic access_fault(input logic       is_load,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic illegal;
        logic misaligned;
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = ~is_load;
            default:          illegal = 1'b1;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                     ((funct3[1:0] == 2'b10) && (offset != 2'b00));
        return illegal | misaligned;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a returned bus word and
// sign- or zero-extends it according to the load's funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfwords are always naturally aligned by the time they get here.
    always_comb begin
        byte_sel = word[8*offset +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'b0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'b0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM memory ops into req/gnt/rvalid
// bus transactions. Define DMEM_TIMEOUT_EN to add a bus watchdog.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic                       mem_valid_i,
    input  logic                       mem_read_i,
    input  logic                       mem_write_i,
    input  logic [2:0]                 funct3_i,
    input  logic [DATA_ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]      store_data_i,
    output logic                       stall_o,
    output logic [DATA_WIDTH-1:0]      load_data_o,
    output logic                       access_fault_o,
    output logic                       bus_err_o,
    output logic                       dmem_req_o,
    output logic                       dmem_we_o,
    output logic [DATA_ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0]      dmem_wdata_o,
    output logic [3:0]                 dmem_wstrb_o,
    input  logic                       dmem_gnt_i,
    input  logic                       dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      dmem_rdata_i
);

    lsu_state_e            state;
    logic                  op;
    logic                  fault;
    logic                  idle_fault;
    logic                  start;
    logic                  complete;
    logic                  timeout;
    logic                  expire;
    logic                  lat_load;
    logic [2:0]            lat_funct3;
    logic [1:0]            lat_offset;
    logic [DATA_WIDTH-1:0] load_q;
    logic [DATA_WIDTH-1:0] aligned;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [3:0]            lane_strb;

    assign op         = mem_valid_i & (mem_read_i | mem_write_i);
    assign fault      = access_fault(mem_read_i, funct3_i, addr_i[1:0]);
    assign idle_fault = (state == LSU_IDLE) & op & fault;
    assign start      = (state == LSU_IDLE) & op & ~fault;

    assign stall_o        = start | (state == LSU_REQ) | (state == LSU_RESP);
    assign access_fault_o = idle_fault;
    assign load_data_o    = idle_fault ? '0 : load_q;

    // A load granted together with rvalid finishes straight from REQ.
    assign complete = ((state == LSU_REQ) & dmem_gnt_i & (~lat_load | dmem_rvalid_i)) |
                      ((state == LSU_RESP) & dmem_rvalid_i);
    assign expire   = timeout & ~complete;

    always_comb begin
        lane_data = store_data_i;
        lane_strb = STRB_W;
        case (funct3_i[1:0])
            2'b00: begin
                lane_data = {4{store_data_i[7:0]}};
                lane_strb = STRB_B << addr_i[1:0];
            end
            2'b01: begin
                lane_data = {2{store_data_i[15:0]}};
                lane_strb = STRB_H << addr_i[1:0];
            end
            default: begin
                lane_data = store_data_i;
                lane_strb = STRB_W;
            end
        endcase
    end

    lsu_load_align u_align (
        .word   (dmem_rdata_i),
        .offset (lat_offset),
        .funct3 (lat_funct3),
        .result (aligned)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             bus_err_q;

    assign timeout   = (state == LSU_REQ || state == LSU_RESP) &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err_o = bus_err_q;

    // bus_err is only ever high during the DONE cycle a timeout leads into.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (start)
                wait_cnt <= '0;
            else if (state == LSU_REQ || state == LSU_RESP)
                wait_cnt <= wait_cnt + 1'b1;
            bus_err_q <= expire;
        end
    end
`else
    assign timeout   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state        <= LSU_IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_wstrb_o <= '0;
            load_q       <= '0;
            lat_load     <= 1'b0;
            lat_funct3   <= '0;
            lat_offset   <= '0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (start) begin
                        state        <= LSU_REQ;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= ~mem_read_i;
                        dmem_addr_o  <= {addr_i[DATA_ADDR_WIDTH-1:2], 2'b00};
                        dmem_wdata_o <= mem_read_i ? '0 : lane_data;
                        dmem_wstrb_o <= mem_read_i ? 4'b0000 : lane_strb;
                        lat_load     <= mem_read_i;
                        lat_funct3   <= funct3_i;
                        lat_offset   <= addr_i[1:0];
                    end
                end
                LSU_REQ: begin
                    if (complete || expire) begin
                        state      <= LSU_DONE;
                        dmem_req_o <= 1'b0;
                    end else if (dmem_gnt_i) begin
                        state      <= LSU_RESP;
                        dmem_req_o <= 1'b0;
                    end
                end
                LSU_RESP: begin
                    if (complete || expire)
                        state <= LSU_DONE;
                end
                LSU_DONE: begin
                    state <= LSU_IDLE;
                end
                default: begin
                    state      <= LSU_IDLE;
                    dmem_req_o <= 1'b0;
                end
            endcase

            if (complete && lat_load)
                load_q <= aligned;
            else if (expire)
                load_q <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu; build with DMEM_TIMEOUT_EN to
// also exercise the watchdog (DUT built with TIMEOUT_CYCLES = 8).
module tb_mem_stage_lsu;

    localparam int TO = 8;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic        mem_valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, store_data_i;
    logic        stall_o, access_fault_o, bus_err_o;
    logic [31:0] load_data_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_load = '0;

    always #5 cpu_clk = ~cpu_clk;

    mem_stage_lsu #(
        .DATA_WIDTH(32), .DATA_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .mem_valid_i(mem_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
        .stall_o(stall_o), .load_data_o(load_data_o),
        .access_fault_o(access_fault_o), .bus_err_o(bus_err_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
    );

    // Reference rules, written from the access-size point of view.
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_legal(input logic ld, input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        if (ld) ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else    ok = (f3 == 0) || (f3 == 1) || (f3 == 2);
        return ok && ((int'(a) % size_of(f3)) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
        longint v;
        longint sh;
        sh = 8 * int'(a);
        if (f3 == 3'b010) return w;
        if (size_of(f3) == 1) begin
            v = (longint'(w) >> sh) % 256;
            if (f3 == 3'b000 && v >= 128) v = v - 256;
        end else begin
            v = (longint'(w) >> sh) % 65536;
            if (f3 == 3'b001 && v >= 32768) v = v - 65536;
        end
        return 32'(v);
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [1:0] a);
        return 4'(((1 << size_of(f3)) - 1) << int'(a));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] r;
        int n;
        n = size_of(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % n) +: 8];
        return r;
    endfunction

    task automatic set_idle();
        mem_valid_i = 0; mem_read_i = 0; mem_write_i = 0; funct3_i = 0;
        addr_i = 0; store_data_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    endtask

    // Runs one op cycle by cycle, checking the bus and stall behaviour throughout.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] word,
                         input int gnt_dly, input int rv_dly, input logic rv_same, input string tag);
        logic legal;
        logic exp_we;
        legal  = model_legal(rd, f3, addr[1:0]);
        exp_we = !rd;
        @(negedge cpu_clk);
        mem_valid_i = 1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
        addr_i = addr; store_data_i = sd; dmem_gnt_i = 0;
        dmem_rvalid_i = 1'($urandom); dmem_rdata_i = $urandom;
        #1;
        if (!legal) begin
            checks++;
            if ({access_fault_o, stall_o, dmem_req_o} !== 3'b100 || load_data_o !== 32'h0) begin
                failures++;
                $display("[TB] FAIL %s fault-cycle fault/stall/req=%b data=%h expected 100 data=0", tag,
                         {access_fault_o, stall_o, dmem_req_o}, load_data_o);
            end
            @(negedge cpu_clk); set_idle(); #1;
            checks++;
            if ({dmem_req_o, stall_o} !== 2'b00 || load_data_o !== last_load) begin
                failures++;
                $display("[TB] FAIL %s after-fault req/stall=%b data=%h expected 00 data=%h", tag,
                         {dmem_req_o, stall_o}, load_data_o, last_load);
            end
            return;
        end
        checks++;
        if ({access_fault_o, stall_o, dmem_req_o} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL %s idle-cycle fault/stall/req=%b expected 010", tag,
                     {access_fault_o, stall_o, dmem_req_o});
        end
        for (int k = 0; k <= gnt_dly; k++) begin
            @(negedge cpu_clk);
            dmem_gnt_i    = (k == gnt_dly);
            dmem_rvalid_i = rd ? (k == gnt_dly && rv_same) : 1'($urandom);
            dmem_rdata_i  = rd ? word : $urandom;
            #1;
            checks++;
            if ({dmem_req_o, stall_o, dmem_we_o} !== {2'b11, exp_we} ||
                dmem_addr_o !== {addr[31:2], 2'b00} || load_data_o !== last_load) begin
                failures++;
                $display("[TB] FAIL %s req-cycle req/stall/we=%b addr=%h data=%h expected %b addr=%h data=%h",
                         tag, {dmem_req_o, stall_o, dmem_we_o}, dmem_addr_o, load_data_o,
                         {2'b11, exp_we}, {addr[31:2], 2'b00}, last_load);
            end
            if (!rd) begin
                checks++;
                if (dmem_wdata_o !== ref_wdata(f3, sd) || dmem_wstrb_o !== ref_wstrb(f3, addr[1:0])) begin
                    failures++;
                    $display("[TB] FAIL %s store-lanes wdata=%h wstrb=%b expected wdata=%h wstrb=%b", tag,
                             dmem_wdata_o, dmem_wstrb_o, ref_wdata(f3, sd), ref_wstrb(f3, addr[1:0]));
                end
            end
        end
        if (rd && !rv_same) begin
            for (int k = 0; k <= rv_dly; k++) begin
                @(negedge cpu_clk);
                dmem_gnt_i    = 1'($urandom);
                dmem_rvalid_i = (k == rv_dly);
                dmem_rdata_i  = (k == rv_dly) ? word : $urandom;
                #1;
                checks++;
                if ({dmem_req_o, stall_o} !== 2'b01 || load_data_o !== last_load) begin
                    failures++;
                    $display("[TB] FAIL %s resp-cycle req/stall=%b data=%h expected 01 data=%h", tag,
                             {dmem_req_o, stall_o}, load_data_o, last_load);
                end
            end
        end
        if (rd) last_load = ref_load(word, addr[1:0], f3);
        // The next instruction may already sit in EX/MEM; DONE must ignore it.
        @(negedge cpu_clk);
        mem_valid_i = 1'($urandom); mem_read_i = 1'($urandom); mem_write_i = 1'($urandom);
        funct3_i = 3'($urandom); addr_i = $urandom;
        dmem_gnt_i = 1'($urandom); dmem_rvalid_i = 1'($urandom); dmem_rdata_i = $urandom;
        #1;
        checks++;
        if ({stall_o, dmem_req_o, access_fault_o, bus_err_o} !== 4'b0000 || load_data_o !== last_load) begin
            failures++;
            $display("[TB] FAIL %s done-cycle stall/req/fault/err=%b data=%h expected 0000 data=%h", tag,
                     {stall_o, dmem_req_o, access_fault_o, bus_err_o}, load_data_o, last_load);
        end
    endtask

    task automatic test_reset();
        set_idle();
        cpu_rst_n = 0;
        #3;
        checks++;
        if ({dmem_req_o, dmem_we_o, dmem_wstrb_o, stall_o, access_fault_o, bus_err_o} !== 9'b0 ||
            dmem_addr_o !== 32'h0 || dmem_wdata_o !== 32'h0 || load_data_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset ctrl=%b addr=%h wdata=%h data=%h expected all zero",
                     {dmem_req_o, dmem_we_o, dmem_wstrb_o, stall_o, access_fault_o, bus_err_o},
                     dmem_addr_o, dmem_wdata_o, load_data_o);
        end
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst_n = 1;
    endtask

    task automatic test_stores();
        do_op(0, 1, 3'b010, 32'h100, 32'h11223344, 32'h0, 0, 0, 0, "sw");
        @(negedge cpu_clk); set_idle(); #1;
        checks++;
        if (dmem_addr_o !== 32'h100 || dmem_wstrb_o !== 4'b1111 || dmem_wdata_o !== 32'h11223344) begin
            failures++;
            $display("[TB] FAIL sw-fields addr=%h wstrb=%b wdata=%h expected 100 1111 11223344",
                     dmem_addr_o, dmem_wstrb_o, dmem_wdata_o);
        end
        do_op(0, 1, 3'b000, 32'h103, 32'h000000AB, 32'h0, 1, 0, 0, "sb");
        @(negedge cpu_clk); set_idle(); #1;
        checks++;
        if (dmem_wdata_o !== 32'hABABABAB || dmem_wstrb_o !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL sb-fields wdata=%h wstrb=%b expected ABABABAB 1000", dmem_wdata_o, dmem_wstrb_o);
        end
        do_op(0, 1, 3'b001, 32'h206, 32'h5555BEEF, 32'h0, 2, 0, 0, "sh");
    endtask

    task automatic test_load_extend();
        logic [31:0] expv [3];
        logic [2:0]  f3v [3];
        expv = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF};
        f3v  = '{3'b000, 3'b100, 3'b001};
        for (int i = 0; i < 3; i++) begin
            do_op(1, 0, f3v[i], 32'h102, 32'h0, 32'h80FF7F01, 0, 2, 0, "load-ext");
            @(negedge cpu_clk); set_idle(); #1;
            checks++;
            if (load_data_o !== expv[i]) begin
                failures++;
                $display("[TB] FAIL load-ext f3=%b data=%h expected %h", f3v[i], load_data_o, expv[i]);
            end
        end
        do_op(1, 0, 3'b101, 32'h002, 32'h0, 32'h9A5B0000, 1, 0, 1, "lhu");
        do_op(1, 1, 3'b010, 32'h008, 32'h0, 32'hCAFEF00D, 0, 1, 0, "rw-as-load");
    endtask

    task automatic test_fault();
        do_op(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0, "lw-misaligned");
        do_op(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 0, "load-f3-011");
        do_op(0, 1, 3'b001, 32'h103, 32'h1234, 32'h0, 0, 0, 0, "sh-misaligned");
        do_op(0, 1, 3'b100, 32'h100, 32'h1234, 32'h0, 0, 0, 0, "store-f3-100");
    endtask

    task automatic test_reset_mid();
        @(negedge cpu_clk);
        set_idle();
        mem_valid_i = 1; mem_read_i = 1; funct3_i = 3'b010; addr_i = 32'h200;
        @(negedge cpu_clk);
        dmem_gnt_i = 1;
        @(negedge cpu_clk);
        set_idle();
        #2 cpu_rst_n = 0;
        #1;
        last_load = '0;
        checks++;
        if ({dmem_req_o, stall_o, dmem_wstrb_o} !== 6'b0 || dmem_addr_o !== 32'h0 || load_data_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset-mid req/stall/wstrb=%b addr=%h data=%h expected zeros",
                     {dmem_req_o, stall_o, dmem_wstrb_o}, dmem_addr_o, load_data_o);
        end
        @(negedge cpu_clk);
        cpu_rst_n = 1;
        @(negedge cpu_clk);
        dmem_rvalid_i = 1; dmem_rdata_i = 32'hDEADBEEF;
        @(negedge cpu_clk);
        dmem_rvalid_i = 0;
        #1;
        checks++;
        if ({dmem_req_o, stall_o} !== 2'b00 || load_data_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL stale-rvalid req/stall=%b data=%h expected 00 data=0",
                     {dmem_req_o, stall_o}, load_data_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                do_op(1, 0, 3'b010, 32'($urandom) & 32'hFFFFFFFC, 32'h0, $urandom, 0, 0, 1, "b2b-load");
            else
                do_op(0, 1, 3'b000, $urandom, $urandom, 32'h0, 0, 0, 0, "b2b-store");
        end
    endtask

    task automatic test_random();
        logic [2:0] lf [5];
        logic       rd, wr;
        logic [2:0] f3;
        logic [31:0] a;
        lf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: begin rd = 1; wr = 0; end
                1: begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
            else f3 = rd ? lf[$urandom_range(0, 4)] : lf[$urandom_range(0, 2)];
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_op(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 3),
                  $urandom_range(0, 2), 1'($urandom), "random");
        end
        @(negedge cpu_clk); set_idle();
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int  n;
        logic ended;
        n = 0;
        ended = 0;
        @(negedge cpu_clk);
        set_idle();
        mem_valid_i = 1; mem_read_i = 1; funct3_i = 3'b010; addr_i = 32'h40;
        for (int i = 0; i < 40 && !ended; i++) begin
            @(negedge cpu_clk);
            #1;
            if (dmem_req_o) n++;
            else ended = 1;
        end
        last_load = '0;
        checks++;
        if (!ended || n != TO || bus_err_o !== 1'b1 || load_data_o !== 32'h0 || stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout ended=%b req-cycles=%0d err=%b data=%h stall=%b expected 1 %0d 1 0 0",
                     ended, n, bus_err_o, load_data_o, stall_o, TO);
        end
        @(negedge cpu_clk); set_idle(); #1;
        checks++;
        if (bus_err_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout-after err=%b req=%b expected 0 0", bus_err_o, dmem_req_o);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_stores();
        test_load_extend();
        test_fault();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
